// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit format, default buffer depth and router port names.
package noc_pkg;

    parameter int unsigned FLIT_W    = 34;
    parameter int unsigned BUF_DEPTH = 4;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [2:0] {
        PortN,
        PortS,
        PortE,
        PortW,
        PortL
    } port_e;

endpackage

// File: rtl/flit_fifo.sv
// Flit storage with wrap-bit pointers; occupancy flags derive purely from registered pointers.
module flit_fifo #(
    parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
    parameter int unsigned DEPTH  = noc_pkg::BUF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned PW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [FLIT_W-1:0] wdata_i,
    output logic [FLIT_W-1:0] rdata_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [PW-1:0]     count_o
);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en_i) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/input_buffer_credit.sv
// Router input port buffer: gates accesses, returns one credit per consumed flit, flags overflow.
module input_buffer_credit #(
    parameter int unsigned FLIT_W = noc_pkg::FLIT_W,
    parameter int unsigned DEPTH  = noc_pkg::BUF_DEPTH,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              valid_i,
    input  logic              read_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [CW-1:0]     count_o,
    output logic              credit_o,
    output logic              ovf_err_o
);

    logic wr_acc, rd_acc;
    logic credit_q, credit_d;
    logic ovf_q, ovf_d;

    // A read at full frees the slot the concurrent write lands in.
    assign rd_acc = read_i && !empty_o;
    assign wr_acc = valid_i && (!full_o || read_i);

    flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (wr_acc),
        .rd_en_i (rd_acc),
        .wdata_i (flit_i),
        .rdata_o (flit_o),
        .empty_o (empty_o),
        .full_o  (full_o),
        .count_o (count_o)
    );

    always_comb begin
        credit_d = rd_acc;
        ovf_d    = ovf_q || (valid_i && full_o && !read_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign credit_o  = credit_q;
    assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_input_buffer_credit.sv
// Self-checking bench for input_buffer_credit: directed table, corner sequences, random traffic.
module tb_input_buffer_credit;

    localparam int unsigned FW    = noc_pkg::FLIT_W;
    localparam int unsigned DEPTH = noc_pkg::BUF_DEPTH;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit_i;
    logic          valid_i;
    logic          read_i;
    logic [FW-1:0] flit_o;
    logic          empty_o;
    logic          full_o;
    logic [CW-1:0] count_o;
    logic          credit_o;
    logic          ovf_err_o;

    input_buffer_credit dut (
        .clk       (clk),
        .rst       (rst),
        .flit_i    (flit_i),
        .valid_i   (valid_i),
        .read_i    (read_i),
        .flit_o    (flit_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .count_o   (count_o),
        .credit_o  (credit_o),
        .ovf_err_o (ovf_err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO as a queue, credit = "a read was accepted last edge".
    logic [FW-1:0] q[$];
    logic          m_credit;
    logic          m_ovf;
    int            up_cnt;

    typedef struct {
        logic          v;
        logic          r;
        logic [FW-1:0] d;
        logic [CW-1:0] cnt;
        logic          emp;
        logic          ful;
        logic          cr;
        logic          ovf;
        logic          fcare;
        logic [FW-1:0] fl;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_credit = 1'b0;
        m_ovf    = 1'b0;
        up_cnt   = DEPTH;
    endtask

    task automatic model_step(input logic v, input logic r, input logic [FW-1:0] d);
        logic rd, wr;
        rd = r && (q.size() > 0);
        wr = v && ((q.size() < DEPTH) || r);
        if (v && (q.size() == DEPTH) && !r) m_ovf = 1'b1;
        up_cnt = up_cnt - int'(v) + int'(m_credit);
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(d);
        m_credit = rd;
    endtask

    task automatic cycle(input logic v, input logic r, input logic [FW-1:0] d);
        valid_i = v;
        read_i  = r;
        flit_i  = d;
        @(posedge clk);
        model_step(v, r, d);
        #1;
    endtask

    task automatic chk_model();
        chk("count", 64'(count_o), 64'(q.size()));
        chk("empty", 64'(empty_o), 64'(q.size() == 0));
        chk("full", 64'(full_o), 64'(q.size() == DEPTH));
        chk("credit", 64'(credit_o), 64'(m_credit));
        chk("ovf", 64'(ovf_err_o), 64'(m_ovf));
        if (q.size() > 0) chk("flit", 64'(flit_o), 64'(q[0]));
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        read_i  = 1'b0;
        rst     = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int credits;

        // Fill 1..4, overflow attempt, drain, read while empty, idle.
        tbl[0]  = '{1'b1, 1'b0, FW'(1),    3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FW'(1)};
        tbl[1]  = '{1'b1, 1'b0, FW'(2),    3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FW'(1)};
        tbl[2]  = '{1'b1, 1'b0, FW'(3),    3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FW'(1)};
        tbl[3]  = '{1'b1, 1'b0, FW'(4),    3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, FW'(1)};
        tbl[4]  = '{1'b1, 1'b0, FW'('h55), 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, FW'(1)};
        tbl[5]  = '{1'b0, 1'b1, FW'(0),    3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, FW'(2)};
        tbl[6]  = '{1'b0, 1'b1, FW'(0),    3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, FW'(3)};
        tbl[7]  = '{1'b0, 1'b1, FW'(0),    3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, FW'(4)};
        tbl[8]  = '{1'b0, 1'b1, FW'(0),    3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, FW'(0)};
        tbl[9]  = '{1'b0, 1'b1, FW'(0),    3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FW'(0)};
        tbl[10] = '{1'b0, 1'b0, FW'(0),    3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FW'(0)};

        rst     = 1'b1;
        valid_i = 1'b0;
        read_i  = 1'b0;
        flit_i  = '0;
        model_clear();
        #1;
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_credit", 64'(credit_o), 64'd0);
        chk("rst_ovf", 64'(ovf_err_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, '0);
            chk("idle_empty", 64'(empty_o), 64'd1);
            chk("idle_count", 64'(count_o), 64'd0);
            chk("idle_credit", 64'(credit_o), 64'd0);
        end

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), 64'(count_o), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_empty", i), 64'(empty_o), 64'(tbl[i].emp));
            chk($sformatf("tbl%0d_full", i), 64'(full_o), 64'(tbl[i].ful));
            chk($sformatf("tbl%0d_credit", i), 64'(credit_o), 64'(tbl[i].cr));
            chk($sformatf("tbl%0d_ovf", i), 64'(ovf_err_o), 64'(tbl[i].ovf));
            if (tbl[i].fcare) chk($sformatf("tbl%0d_flit", i), 64'(flit_o), 64'(tbl[i].fl));
        end

        // Streaming at full across several pointer wraps.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, FW'(32'h100 + i));
            chk_model();
        end
        credits = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, FW'(32'h200 + i));
            chk_model();
            chk("stream_count", 64'(count_o), 64'(DEPTH));
            credits += int'(credit_o);
        end
        cycle(1'b0, 1'b0, '0);
        chk_model();
        credits += int'(credit_o);
        chk("stream_credits", 64'(credits), 64'd20);

        // Asynchronous reset with flits held and a credit pulse in flight.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, FW'(32'h300 + i));
        cycle(1'b0, 1'b1, '0);
        chk_model();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("async_credit", 64'(credit_o), 64'd0);
        chk("async_count", 64'(count_o), 64'd0);
        chk("async_empty", 64'(empty_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0);
            chk_model();
        end

        // Random traffic from a credit-respecting upstream.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic v, r;
            v = (up_cnt > 0) && ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 50);
            cycle(v, r, FW'({$urandom(), $urandom()}));
            chk_model();
            chk("credit_invariant", 64'(int'(count_o) + int'(credit_o) + up_cnt), 64'(DEPTH));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
